// File: rtl/hazard_ctrl_gen.sv
// hazard_ctrl_gen: stall, flush and operand-forwarding control for an in-order
// pipeline F, D, E followed by NFWD result-carrying stages (index 0 = M,
// NFWD-1 = W). Also tracks fetch/data responses made stale by a redirect so
// that the late response is squashed when it finally arrives.
// Optional build macro HAZARD_PERF_EN adds saturating per-cause stall counters.
module hazard_ctrl_gen #(
  parameter int NFWD = 3,
  parameter int RW   = 5,
  parameter int FW   = $clog2(NFWD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RW-1:0]      ra1D,
  input  logic [RW-1:0]      ra2D,
  input  logic [RW-1:0]      ra1E,
  input  logic [RW-1:0]      ra2E,
  input  logic [RW-1:0]      edst,
  input  logic               wrE,
  input  logic               ldE,
  input  logic [NFWD*RW-1:0] dst,
  input  logic [NFWD-1:0]    wr,
  input  logic [NFWD-1:0]    ld,
  input  logic               branchD,
  input  logic               redirectD,
  input  logic               multiD,
  input  logic               i_wait,
  input  logic               d_wait,
  input  logic               e_wait,
  input  logic               trapW,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallP,
  output logic               flushD,
  output logic               flushE,
  output logic               flushP,
  output logic               flushW,
  output logic [FW-1:0]      fwdaD,
  output logic [FW-1:0]      fwdbD,
  output logic [FW-1:0]      fwdaE,
  output logic [FW-1:0]      fwdbE,
  output logic               drop_i,
  output logic               drop_d
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        cnt_lw,
  output logic [31:0]        cnt_br,
  output logic [31:0]        cnt_mul,
  output logic [31:0]        cnt_mem
`endif
);

  // x0 never carries a dependency
  function automatic logic match(input logic [RW-1:0] r, input logic [RW-1:0] d);
    return (r != '0) && (r == d);
  endfunction

  // youngest writing stage wins, 0 selects the register file
  function automatic logic [FW-1:0] fsel(input logic [RW-1:0]      r,
                                         input logic [NFWD*RW-1:0] dv,
                                         input logic [NFWD-1:0]    wv);
    logic [FW-1:0] s;
    s = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (wv[k] && match(r, dv[k*RW +: RW])) s = FW'(k + 1);
    end
    return s;
  endfunction

  logic e_hit;
  logic post_wr_hit;
  logic post_ld_hit;
  logic lwstall;
  logic brstall;
  logic mulstall;
  logic hz;
  logic set_i;
  logic set_d;

  // D-stage source dependencies against E and the post-E group
  always_comb begin
    e_hit       = match(ra1D, edst) | match(ra2D, edst);
    post_wr_hit = 1'b0;
    post_ld_hit = 1'b0;
    for (int k = 0; k < NFWD; k++) begin
      if (wr[k] && (match(ra1D, dst[k*RW +: RW]) || match(ra2D, dst[k*RW +: RW]))) begin
        post_wr_hit = 1'b1;
        if (ld[k]) post_ld_hit = 1'b1;
      end
    end
    lwstall  = (ldE & e_hit) | post_ld_hit;
    brstall  = branchD & ((wrE & e_hit) | post_ld_hit);
    mulstall = multiD & ((wrE & e_hit) | post_wr_hit);
    hz       = lwstall | brstall | mulstall;
    set_i    = (trapW | (redirectD & ~hz)) & i_wait;
    set_d    = trapW & d_wait;
  end

  // prioritised stall/flush decode; stale-response squash overlays the result
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallP = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushP = 1'b0;
    flushW = 1'b0;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushP = 1'b1;
      flushW = 1'b1;
    end else begin
      if (trapW) begin
        flushD = 1'b1;
        flushE = 1'b1;
        flushP = 1'b1;
        flushW = 1'b1;
        stallF = i_wait;
      end else if (e_wait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        if (d_wait) stallP = 1'b1;
        else        flushP = 1'b1;
      end else if (d_wait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallP = 1'b1;
      end else if (i_wait) begin
        stallF = 1'b1;
        if (redirectD | hz) begin
          stallD = 1'b1;
          flushE = 1'b1;
        end else begin
          flushD = 1'b1;
        end
      end else begin
        stallF = hz;
        stallD = hz;
        flushE = hz;
        flushD = redirectD & ~hz;
      end
      if (drop_i && !i_wait) flushD = 1'b1;
      if (drop_d && !d_wait) flushP = 1'b1;
    end
  end

  // operand forwarding selects; E selects parked while the multi-cycle unit runs
  always_comb begin
    fwdaD = '0;
    fwdbD = '0;
    fwdaE = '0;
    fwdbE = '0;
    if (!reset) begin
      fwdaD = fsel(ra1D, dst, wr);
      fwdbD = fsel(ra2D, dst, wr);
      if (!e_wait) begin
        fwdaE = fsel(ra1E, dst, wr);
        fwdbE = fsel(ra2E, dst, wr);
      end
    end
  end

  // stale-response flags: set on redirect during an outstanding access, clear once it lands
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_i <= 1'b0;
      drop_d <= 1'b0;
    end else begin
      if (set_i)        drop_i <= 1'b1;
      else if (!i_wait) drop_i <= 1'b0;
      if (set_d)        drop_d <= 1'b1;
      else if (!d_wait) drop_d <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic hz_owns_stall;
  logic mem_owns_stall;

  // only the cause that actually drives stallD is credited
  always_comb begin
    hz_owns_stall  = ~reset & ~trapW & ~e_wait & ~d_wait;
    mem_owns_stall = ~reset & ~trapW & (e_wait | d_wait);
  end

  // saturating per-cause stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lw  <= '0;
      cnt_br  <= '0;
      cnt_mul <= '0;
      cnt_mem <= '0;
    end else begin
      if (hz_owns_stall && lwstall && cnt_lw != '1)   cnt_lw  <= cnt_lw + 32'd1;
      if (hz_owns_stall && brstall && cnt_br != '1)   cnt_br  <= cnt_br + 32'd1;
      if (hz_owns_stall && mulstall && cnt_mul != '1) cnt_mul <= cnt_mul + 32'd1;
      if (mem_owns_stall && cnt_mem != '1)            cnt_mem <= cnt_mem + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Scoreboard bench for hazard_ctrl_gen: a driver issues one stimulus vector per
// cycle and queues the reference-model response; a monitor compares on negedge.
module tb_hazard_ctrl_gen;
  localparam int NFWD = 3;
  localparam int RW   = 5;
  localparam int FW   = $clog2(NFWD + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [RW-1:0]      ra1D, ra2D, ra1E, ra2E, edst;
  logic               wrE, ldE;
  logic [NFWD*RW-1:0] dst;
  logic [NFWD-1:0]    wr, ld;
  logic               branchD, redirectD, multiD, i_wait, d_wait, e_wait, trapW;
  logic               stallF, stallD, stallE, stallP;
  logic               flushD, flushE, flushP, flushW;
  logic [FW-1:0]      fwdaD, fwdbD, fwdaE, fwdbE;
  logic               drop_i, drop_d;
`ifdef HAZARD_PERF_EN
  logic [31:0]        cnt_lw, cnt_br, cnt_mul, cnt_mem;
`endif

  hazard_ctrl_gen #(.NFWD(NFWD), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
    .edst(edst), .wrE(wrE), .ldE(ldE),
    .dst(dst), .wr(wr), .ld(ld),
    .branchD(branchD), .redirectD(redirectD), .multiD(multiD),
    .i_wait(i_wait), .d_wait(d_wait), .e_wait(e_wait), .trapW(trapW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallP(stallP),
    .flushD(flushD), .flushE(flushE), .flushP(flushP), .flushW(flushW),
    .fwdaD(fwdaD), .fwdbD(fwdbD), .fwdaE(fwdaE), .fwdbE(fwdbE),
    .drop_i(drop_i), .drop_d(drop_d)
`ifdef HAZARD_PERF_EN
    ,
    .cnt_lw(cnt_lw), .cnt_br(cnt_br), .cnt_mul(cnt_mul), .cnt_mem(cnt_mem)
`endif
  );

  typedef struct {
    logic               reset;
    logic [RW-1:0]      ra1D, ra2D, ra1E, ra2E, edst;
    logic               wrE, ldE;
    logic [NFWD*RW-1:0] dst;
    logic [NFWD-1:0]    wr, ld;
    logic               branchD, redirectD, multiD, i_wait, d_wait, e_wait, trapW;
  } stim_t;

  typedef struct {
    logic [3:0]      stall;  // F D E P
    logic [3:0]      flush;  // D E P W
    logic [4*FW-1:0] fwd;    // aD bD aE bE
    logic [1:0]      drop;   // i d
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mi = 1'b0;
  bit   md = 1'b0;

  function automatic bit dep(logic [RW-1:0] r, logic [RW-1:0] d);
    return (r != 0) && (r == d);
  endfunction

  // producers: slot 0 is E, slot p>0 is post-E stage p-1
  function automatic void hazards(stim_t s, output bit lw, output bit br, output bit mul);
    logic [RW-1:0] src[2];
    src[0] = s.ra1D;
    src[1] = s.ra2D;
    lw = 0; br = 0; mul = 0;
    for (int p = 0; p <= NFWD; p++) begin
      logic [RW-1:0] d;
      bit notready, writes, brdep;
      if (p == 0) begin
        d = s.edst; notready = s.ldE; writes = s.wrE; brdep = s.wrE;
      end else begin
        d = s.dst[(p-1)*RW +: RW];
        writes = s.wr[p-1];
        notready = s.ld[p-1] & s.wr[p-1];
        brdep = notready;
      end
      for (int j = 0; j < 2; j++) begin
        if (dep(src[j], d)) begin
          if (notready) lw = 1;
          if (s.branchD && brdep) br = 1;
          if (s.multiD && writes) mul = 1;
        end
      end
    end
  endfunction

  function automatic logic [FW-1:0] pick(logic [RW-1:0] r, stim_t s);
    for (int k = 0; k < NFWD; k++)
      if (s.wr[k] && dep(r, s.dst[k*RW +: RW])) return FW'(k + 1);
    return '0;
  endfunction

  function automatic exp_t model(stim_t s, bit di, bit dd);
    exp_t e;
    bit lw, br, mul, hz;
    bit sF, sD, sE, sP, fD, fE, fP, fW;
    int lvl;
    hazards(s, lw, br, mul);
    hz = lw | br | mul;
    {sF, sD, sE, sP, fD, fE, fP, fW} = '0;
    lvl = s.reset ? 0 : s.trapW ? 1 : s.e_wait ? 2 : s.d_wait ? 3 : s.i_wait ? 4 : 5;
    case (lvl)
      0: {fD, fE, fP, fW} = 4'b1111;
      1: begin {fD, fE, fP, fW} = 4'b1111; sF = s.i_wait; end
      2: begin {sF, sD, sE} = 3'b111; sP = s.d_wait; fP = !s.d_wait; end
      3: {sF, sD, sE, sP} = 4'b1111;
      4: begin
        sF = 1;
        if (s.redirectD || hz) begin sD = 1; fE = 1; end
        else fD = 1;
      end
      default: begin sF = hz; sD = hz; fE = hz; fD = s.redirectD && !hz; end
    endcase
    if (lvl != 0 && di && !s.i_wait) fD = 1;
    if (lvl != 0 && dd && !s.d_wait) fP = 1;
    e.stall = {sF, sD, sE, sP};
    e.flush = {fD, fE, fP, fW};
    if (s.reset) e.fwd = '0;
    else e.fwd = {pick(s.ra1D, s), pick(s.ra2D, s),
                  s.e_wait ? FW'(0) : pick(s.ra1E, s),
                  s.e_wait ? FW'(0) : pick(s.ra2E, s)};
    e.drop = {di, dd};
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.ra1D = 0; s.ra2D = 0; s.ra1E = 0; s.ra2E = 0; s.edst = 0;
    s.wrE = 0; s.ldE = 0; s.dst = '0; s.wr = '0; s.ld = '0;
    s.branchD = 0; s.redirectD = 0; s.multiD = 0;
    s.i_wait = 0; s.d_wait = 0; s.e_wait = 0; s.trapW = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.reset; ra1D = s.ra1D; ra2D = s.ra2D; ra1E = s.ra1E; ra2E = s.ra2E;
    edst = s.edst; wrE = s.wrE; ldE = s.ldE; dst = s.dst; wr = s.wr; ld = s.ld;
    branchD = s.branchD; redirectD = s.redirectD; multiD = s.multiD;
    i_wait = s.i_wait; d_wait = s.d_wait; e_wait = s.e_wait; trapW = s.trapW;
  endtask

  task automatic step(input stim_t s);
    bit lw, br, mul;
    @(posedge clk);
    #1;
    apply(s);
    q.push_back(model(s, mi, md));
    hazards(s, lw, br, mul);
    if (s.reset) begin
      mi = 0; md = 0;
    end else begin
      mi = ((s.trapW || (s.redirectD && !(lw || br || mul))) && s.i_wait) || (mi && s.i_wait);
      md = (s.trapW && s.d_wait) || (md && s.d_wait);
    end
  endtask

  // monitor: outputs are presented every cycle, compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({stallF, stallD, stallE, stallP} !== e.stall) begin
          errors++;
          $display("FAIL stall t=%0t got %b exp %b", $time, {stallF, stallD, stallE, stallP}, e.stall);
        end
        checks++;
        if ({flushD, flushE, flushP, flushW} !== e.flush) begin
          errors++;
          $display("FAIL flush t=%0t got %b exp %b", $time, {flushD, flushE, flushP, flushW}, e.flush);
        end
        checks++;
        if ({fwdaD, fwdbD, fwdaE, fwdbE} !== e.fwd) begin
          errors++;
          $display("FAIL fwd t=%0t got %h exp %h", $time, {fwdaD, fwdbD, fwdaE, fwdbE}, e.fwd);
        end
        checks++;
        if ({drop_i, drop_d} !== e.drop) begin
          errors++;
          $display("FAIL drop t=%0t got %b exp %b", $time, {drop_i, drop_d}, e.drop);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1;
    apply(s);
    step(s);
    step(s);

    // load-use, then the producer reaches M and forwards
    s = idle(); s.ldE = 1; s.wrE = 1; s.edst = 5; s.ra1D = 5;
    step(s);
    s = idle(); s.ra1E = 5; s.wr = 3'b001; s.dst[0 +: RW] = 5;
    step(s);

    // forward priority among stages
    s = idle(); s.dst = {5'd7, 5'd7, 5'd7}; s.wr = 3'b110; s.ra2E = 7;
    step(s);
    s.ra2E = 0;
    step(s);

    // x0 exclusion and multi-cycle dependency
    s = idle(); s.multiD = 1; s.wrE = 1; s.edst = 0; s.ra1D = 0;
    step(s);
    s.ra1D = 3; s.dst[RW +: RW] = 3; s.wr = 3'b010;
    step(s);

    // stale fetch after redirect
    s = idle(); s.redirectD = 1; s.i_wait = 1;
    repeat (3) step(s);
    s = idle();
    repeat (2) step(s);

    // trap during outstanding data access, then reset clears the flag
    s = idle(); s.trapW = 1; s.d_wait = 1;
    step(s);
    s = idle(); s.d_wait = 1;
    step(s);
    s = idle();
    repeat (2) step(s);
    s.trapW = 1; s.d_wait = 1;
    step(s);
    s = idle(); s.reset = 1;
    step(s);
    s = idle();
    step(s);

    // e_wait and d_wait together with a pending hazard
    s = idle(); s.e_wait = 1; s.d_wait = 1; s.ldE = 1; s.edst = 5; s.ra1D = 5;
    repeat (2) step(s);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      s.reset     = ($urandom_range(0, 49) == 0);
      s.ra1D      = RW'($urandom_range(0, 3));
      s.ra2D      = RW'($urandom_range(0, 3));
      s.ra1E      = RW'($urandom_range(0, 3));
      s.ra2E      = RW'($urandom_range(0, 3));
      s.edst      = RW'($urandom_range(0, 3));
      s.wrE       = $urandom_range(0, 1);
      s.ldE       = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NFWD; k++) s.dst[k*RW +: RW] = RW'($urandom_range(0, 3));
      s.wr        = NFWD'($urandom);
      s.ld        = NFWD'($urandom) & NFWD'($urandom);
      s.branchD   = ($urandom_range(0, 2) == 0);
      s.redirectD = ($urandom_range(0, 2) == 0);
      s.multiD    = ($urandom_range(0, 2) == 0);
      s.i_wait    = ($urandom_range(0, 3) == 0);
      s.d_wait    = ($urandom_range(0, 4) == 0);
      s.e_wait    = ($urandom_range(0, 4) == 0);
      s.trapW     = ($urandom_range(0, 11) == 0);
      step(s);
    end

    s = idle();
    step(s);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_gen.md
Name: hazard_ctrl_gen

Overview:
- Parametrised hazard, stall/flush and forwarding controller for the in-order pipeline F, D, E, then NFWD result-carrying stages (post-E group; last one is W).
- Generalises the fixed M/M2/W hazard logic to any post-execute depth, with uniform x0 exclusion and a per-stage "result not ready" flag.
- Adds registered stale-response tracking: redirects that occur while an I-side or D-side access is outstanding are tracked, and the late response is squashed.
- Optional per-cause stall counters.

Parameters:
- NFWD, 3: number of post-E forwarding sources, index 0 youngest (M) to NFWD-1 oldest (W).
- RW, 5: register address width.
- FW, $clog2(NFWD+1): forward-select width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ra1D, ra2D  in  RW  source regs of instruction in D
- ra1E, ra2E  in  RW  source regs of instruction in E
- edst  in  RW  destination of E
- wrE  in  1  E writes edst
- ldE  in  1  E result not produced until a later stage (load/CSR)
- dst  in  NFWD*RW  packed destinations; slice k = stage k
- wr  in  NFWD  stage k writes dst[k]
- ld  in  NFWD  stage k result not yet available for forwarding
- branchD  in  1  D instruction resolves a branch and needs operands in D
- redirectD  in  1  D redirects fetch (taken branch or jump)
- multiD  in  1  D instruction is a multi-cycle ALU op
- i_wait, d_wait, e_wait  in  1  I-cache, D-cache and multi-cycle unit busy
- trapW  in  1  W redirect (trap or mret)
- stallF, stallD, stallE, stallP  out  1  hold F/D/E/post-E group
- flushD, flushE, flushP, flushW  out  1  bubble D/E/post-E group (except W)/W
- fwdaD, fwdbD, fwdaE, fwdbE  out  FW  0 = regfile; k+1 = stage k
- drop_i, drop_d  out  1  registered stale-response flags (visible state)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high. Sampled at posedge clk.
- Reset state: drop_i = drop_d = 0, counters = 0.
- Reset outputs: while reset=1, all stalls = 0, all flushes = 1, all fwd = 0.
- Match rule: match(r, d) = (r != 0) && (r == d). This applies to every comparison below.
- Hazard terms, computed against D sources a = ra1D, b = ra2D:
  - lwstall = ldE&match(a|b, edst) | OR_k(ld[k] & wr[k] & match(a|b, dst[k])).
  - brstall = branchD & (wrE&match(a|b, edst) | OR_k(ld[k]&wr[k]&match(a|b, dst[k]))).
  - mulstall = multiD & (wrE&match(a|b, edst) | OR_k(wr[k]&match(a|b, dst[k]))).
  - hz = lwstall | brstall | mulstall.
- Priority is strict, first match wins:
  1. trapW: flushD = flushE = flushP = flushW = 1. If i_wait, also stallF = 1.
  2. e_wait: stallF = stallD = stallE = 1.
     - If d_wait: stallP = 1, flushP = 0.
     - Else: flushP = 1, which bubbles the slot after E.
  3. d_wait: stallF = stallD = stallE = stallP = 1.
  4. i_wait: stallF = 1 and flushD = 1.
     - If redirectD | hz: stallD = 1, flushD = 0, flushE = 1.
  5. Otherwise: stallF = stallD = flushE = hz; flushD = redirectD & ~hz.
- Stale-response flags:
  - drop_i sets next cycle when (trapW | (redirectD & ~hz)) & i_wait.
  - drop_d sets when trapW & d_wait.
  - When drop_i=1 and i_wait=0: flushD forced 1 that cycle; drop_i clears next cycle.
  - When drop_d=1 and d_wait=0: flushP forced 1 that cycle; drop_d clears next cycle.
  - Set and clear in the same cycle: set wins.
  - reset mid-operation clears both flags.
- Forwarding (combinational, zero latency):
  - For each source r, select the lowest k with wr[k] & match(r, dst[k]); fwd = k+1, else 0.
  - E selects are forced to 0 while e_wait=1.
  - Stages with ld[k]=1 are still selected; the stall terms guarantee they are never consumed.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs cnt_lw, cnt_br, cnt_mul, cnt_mem, each 32 bits. Each increments once per cycle in which the corresponding cause actually asserts stallD: lwstall, brstall, mulstall, or d_wait | e_wait respectively. Counters saturate at 2^32-1 and clear on reset.
- Undefined: these ports and their logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Load-use: ldE=1, edst=5, ra1D=5 → stallF = stallD = flushE = 1 and fwdaD = 0. Next cycle, with ld[0]=0, wr[0]=1, dst[0]=5 → stall drops and fwdaE = 1.
- Forward priority, NFWD=3: dst = {7,7,7}, wr = 3'b110, ra2E=7 → fwdbE = 2. With ra2E=0 → fwdbE = 0.
- x0 exclusion: multiD=1, ra1D=0, wrE=1, edst=0 → no stall. With edst=0 and ra1D=3, dst[1]=3, wr[1]=1 → stallD = 1.
- Stale fetch: redirectD=1 while i_wait=1 for 3 cycles → drop_i=1 from cycle 1. When i_wait falls, flushD = 1 for exactly one cycle, then drop_i = 0.
- trapW with d_wait=1 → all flushes = 1 and drop_d = 1. On d_wait fall → flushP = 1 once. Asserting reset while drop_d=1 → drop_d = 0 next cycle.
- Precedence: e_wait = d_wait = 1 with hz=1 → stallP = 1, flushP = 0, flushE = 0. With HAZARD_PERF_EN, cnt_mem increments by 1 per such cycle.
